sar_search_ctrl: RTL and testbench
==================================

Name: sar_search_ctrl

Overview:
Successive-approximation controller that drives the probe operand of an external magnitude comparator and consumes its equal/greater/less flags. It binary-searches for the hidden operand held on the comparator's other input. It sits on the initiator side of the comparator interface: it produces b, and the comparator answers e/g/l for a versus b. Completion is signalled with a one-cycle done pulse, the located value, and a step count.

Parameters:
WIDTH, 4, operand width of the comparator; search range is 0 .. 2^WIDTH-1.

Ports:
clk  input  1  single clock, rising-edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  begin a search; sampled only in IDLE.
cmp_e  input  1  comparator a==b flag.
cmp_g  input  1  comparator a>b flag.
cmp_l  input  1  comparator a<b flag.
probe  output  WIDTH  registered value driven to the comparator b input.
busy  output  1  high while in EVAL.
done  output  1  one-cycle pulse when a search ends (any outcome).
found  output  1  the last search ended on cmp_e; held until the next start.
err  output  1  the last search ended on an invalid flag code or step overrun; held until the next start.
result  output  WIDTH  probe value at which cmp_e was seen; 0 if not found; held until the next start.
steps  output  WIDTH  number of comparisons consumed by the last or current search.

Behaviour:
- Clock and reset: one clock (clk), rising edge. rst_n is asynchronous and active-low. Reset is asynchronous assert; release is synchronous to clk.
- Reset values: state=IDLE, probe=0, busy=0, done=0, found=0, err=0, result=0, steps=0, lo=0, hi=0.
- Internal range registers lo and hi are WIDTH bits. Midpoint is computed as (lo+hi)>>1 in WIDTH+1-bit arithmetic, with no overflow.
- States: IDLE, EVAL.
- IDLE:
  - done=0 except in the cycle after a search ends.
  - On start=1: lo=0, hi=2^WIDTH-1, probe=(2^WIDTH-1)>>1, steps=0, found=0, err=0, result=0, then go to EVAL.
- EVAL:
  - The comparator is combinational, so flags are sampled on each rising edge against the probe driven during that cycle.
  - Each sample increments steps by 1.
  - Valid codes are exactly one of e/g/l high.
  - cmp_e: result=probe, found=1, done=1 next cycle, go to IDLE.
  - cmp_g:
    - If probe==2^WIDTH-1, the range is empty: found=0, err=0, done, go to IDLE.
    - Otherwise lo=probe+1 and probe=midpoint(probe+1, hi).
  - cmp_l:
    - If probe==0, the range is empty: found=0, err=0, done, go to IDLE.
    - Otherwise hi=probe-1 and probe=midpoint(lo, probe-1).
  - Invalid code (zero flags, or more than one flag high): err=1, found=0, done, go to IDLE.
  - Overrun: if steps would reach WIDTH+2 without cmp_e, set err=1, done, go to IDLE. A consistent comparator always finishes within WIDTH+1 comparisons.
- busy=1 exactly while state==EVAL.
- probe holds its last value in IDLE.
- Latency: with N comparisons, done rises N+1 cycles after the cycle in which start is sampled.
- start while busy is ignored.
- start in the same cycle done=1 is accepted, because the block is already in IDLE.
- rst_n asserted mid-search aborts immediately to reset values; no done pulse is issued.
- Flags are don't-care in IDLE.

Test Plan:
1. WIDTH=4, bench comparator with a=7; pulse start -> probe=7, one step; done 2 cycles after start; found=1, result=7, steps=1, err=0.
2. a=15 -> probe sequence 7,11,13,14,15; done 6 cycles after start; result=15, steps=5.
3. a=0 -> probe sequence 7,3,1,0; result=0, steps=4. Then a=10 -> probes 7,11,9,10; steps=4.
4. Force cmp_e=cmp_g=1 on the second probe -> done pulse, err=1, found=0, result=0, steps=2. Force all flags 0 -> same err outcome.
5. Bench comparator that always reports cmp_g but lies at probe 15 by reporting cmp_g there -> empty-range exit at probe 15, found=0, err=0. A comparator alternating g/l so that no range empties within WIDTH+1 steps -> err=1, steps=WIDTH+1.
6. Control cases:
   - start pulsed while busy -> ignored.
   - rst_n low during the 3rd step -> all outputs return to reset values immediately, no done.
   - start held high through a done pulse -> next search begins with no idle gap.

Source files
------------

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives the comparator probe operand
// and narrows [lo, hi] from the e/g/l answers until it is equal, empty, invalid or overrun.
module sar_search_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_e,
    input  logic             cmp_g,
    input  logic             cmp_l,
    output logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] steps
);

    typedef enum logic {
        IDLE,
        EVAL
    } state_t;

    localparam logic [WIDTH-1:0] MAX_VAL    = '1;
    localparam int               STEP_MAX   = WIDTH + 1;
    localparam logic [WIDTH:0]   STEP_LIMIT = STEP_MAX[WIDTH:0];

    state_t           state;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;

    logic [WIDTH:0]   steps_inc;
    logic [WIDTH-1:0] probe_up;
    logic [WIDTH-1:0] probe_dn;
    logic [WIDTH-1:0] mid_up;
    logic [WIDTH-1:0] mid_dn;
    logic             last_step;

    // Midpoints use a WIDTH+1-bit sum so lo+hi never wraps.
    assign steps_inc = {1'b0, steps} + 1'b1;
    assign probe_up  = probe + 1'b1;
    assign probe_dn  = probe - 1'b1;
    assign mid_up    = WIDTH'(({1'b0, probe_up} + {1'b0, hi}) >> 1);
    assign mid_dn    = WIDTH'(({1'b0, lo} + {1'b0, probe_dn}) >> 1);
    assign last_step = (steps_inc == STEP_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            probe  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            found  <= 1'b0;
            err    <= 1'b0;
            result <= '0;
            steps  <= '0;
            lo     <= '0;
            hi     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        lo     <= '0;
                        hi     <= MAX_VAL;
                        probe  <= MAX_VAL >> 1;
                        steps  <= '0;
                        found  <= 1'b0;
                        err    <= 1'b0;
                        result <= '0;
                        busy   <= 1'b1;
                        state  <= EVAL;
                    end
                end
                EVAL: begin
                    steps <= steps_inc[WIDTH-1:0];
                    case ({cmp_e, cmp_g, cmp_l})
                        3'b100: begin
                            result <= probe;
                            found  <= 1'b1;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= IDLE;
                        end
                        3'b010: begin
                            // An empty range takes priority over the step-overrun check.
                            if (probe == MAX_VAL) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else if (last_step) begin
                                err   <= 1'b1;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                lo    <= probe_up;
                                probe <= mid_up;
                            end
                        end
                        3'b001: begin
                            if (probe == '0) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else if (last_step) begin
                                err   <= 1'b1;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                hi    <= probe_dn;
                                probe <= mid_dn;
                            end
                        end
                        default: begin
                            err   <= 1'b1;
                            found <= 1'b0;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    endcase
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl: a behavioural comparator with honest and faulty modes,
// plus an integer reference search that predicts probes, outcome and step count.
module tb_sar_search_ctrl;

    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         cmp_e, cmp_g, cmp_l;
    logic [W-1:0] probe, result, steps;
    logic         busy, done, found, err;

    int tests = 0;
    int fails = 0;

    // comparator behaviour: 0 honest, 1 e+g at step cur_bad, 2 no flags at step cur_bad,
    // 3 always "greater", 4 alternating greater/less by step parity
    int cur_mode = 0;
    int cur_a    = 0;
    int cur_bad  = 0;
    int cur_step = 0;

    int exp_probes[$];
    int exp_steps, exp_found, exp_err, exp_result;

    always #5 clk = ~clk;

    sar_search_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .cmp_e  (cmp_e),
        .cmp_g  (cmp_g),
        .cmp_l  (cmp_l),
        .probe  (probe),
        .busy   (busy),
        .done   (done),
        .found  (found),
        .err    (err),
        .result (result),
        .steps  (steps)
    );

    function automatic logic [2:0] resp(input int mode, input int a, input int bad, input int p, input int n);
        logic [2:0] honest;
        if (a == p)     honest = 3'b100;
        else if (a > p) honest = 3'b010;
        else            honest = 3'b001;
        case (mode)
            1:       return (n == bad) ? 3'b110 : honest;
            2:       return (n == bad) ? 3'b000 : honest;
            3:       return 3'b010;
            4:       return (n % 2 == 1) ? 3'b010 : 3'b001;
            default: return honest;
        endcase
    endfunction

    assign {cmp_e, cmp_g, cmp_l} = resp(cur_mode, cur_a, cur_bad, int'(probe), cur_step);

    // Reference: plain integer binary search over [0, MAXV] with the exit rules.
    task automatic model(input int mode, input int a, input int bad);
        int lo, hi, p, n;
        logic [2:0] f;
        exp_probes.delete();
        exp_found  = 0;
        exp_err    = 0;
        exp_result = 0;
        lo = 0;
        hi = MAXV;
        p  = (lo + hi) / 2;
        n  = 0;
        while (1) begin
            n++;
            exp_probes.push_back(p);
            f = resp(mode, a, bad, p, n);
            if (f == 3'b100) begin
                exp_found  = 1;
                exp_result = p;
                break;
            end
            if (f != 3'b010 && f != 3'b001) begin
                exp_err = 1;
                break;
            end
            if ((f == 3'b010 && p == MAXV) || (f == 3'b001 && p == 0)) break;
            if (n == W + 1) begin
                exp_err = 1;
                break;
            end
            if (f == 3'b010) lo = p + 1;
            else             hi = p - 1;
            p = (lo + hi) / 2;
        end
        exp_steps = n;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic chk_outcome(input string tag);
        chk({tag, ".done"},   32'(done),   1);
        chk({tag, ".busy"},   32'(busy),   0);
        chk({tag, ".found"},  32'(found),  exp_found);
        chk({tag, ".err"},    32'(err),    exp_err);
        chk({tag, ".result"}, 32'(result), exp_result);
        chk({tag, ".steps"},  32'(steps),  exp_steps);
    endtask

    task automatic run_search(input int mode, input int a, input int bad,
                              input bit poke_busy, input bit hold_end, input string tag);
        int n;
        model(mode, a, bad);
        n = exp_probes.size();
        cur_mode = mode;
        cur_a    = a;
        cur_bad  = bad;
        cur_step = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= n; k++) begin
            if (k > 1) @(negedge clk);
            cur_step = k;
            chk({tag, ".busy_eval"}, 32'(busy), 1);
            chk({tag, ".probe"},     32'(probe), exp_probes[k-1]);
            chk({tag, ".done_eval"}, 32'(done), 0);
            if (poke_busy && k == 2) start = 1'b1;
            if (poke_busy && k == 3) start = 1'b0;
            if (hold_end && k == n)  start = 1'b1;
        end
        @(negedge clk);
        chk_outcome(tag);
        if (!hold_end) begin
            @(negedge clk);
            chk({tag, ".done_pulse"}, 32'(done), 0);
            chk({tag, ".found_held"}, 32'(found), exp_found);
            chk({tag, ".probe_held"}, 32'(probe), exp_probes[n-1]);
        end
    endtask

    initial begin
        int a;
        bit seen;

        #2;
        chk("rst.probe",  32'(probe),  0);
        chk("rst.busy",   32'(busy),   0);
        chk("rst.done",   32'(done),   0);
        chk("rst.found",  32'(found),  0);
        chk("rst.err",    32'(err),    0);
        chk("rst.result", 32'(result), 0);
        chk("rst.steps",  32'(steps),  0);
        @(negedge clk);
        rst_n = 1'b1;

        run_search(0, 7,  0, 1'b0, 1'b0, "a7");
        run_search(0, 15, 0, 1'b0, 1'b0, "a15");
        run_search(0, 0,  0, 1'b0, 1'b0, "a0");
        run_search(0, 10, 0, 1'b0, 1'b0, "a10");
        run_search(1, 12, 2, 1'b0, 1'b0, "inv_eg");
        run_search(2, 12, 2, 1'b0, 1'b0, "inv_none");
        run_search(3, 0,  0, 1'b0, 1'b0, "lie_g");
        run_search(4, 0,  0, 1'b0, 1'b0, "overrun");
        run_search(0, 15, 0, 1'b1, 1'b0, "busy_start");

        for (int i = 0; i < 16; i++) begin
            a = $urandom_range(0, MAXV);
            run_search(0, a, 0, 1'b0, 1'b0, $sformatf("rnd%0d", i));
        end

        // reset while the third comparison is in flight
        cur_mode = 0;
        cur_a    = 15;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort.probe_pre", 32'(probe), 13);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.probe",  32'(probe),  0);
        chk("abort.busy",   32'(busy),   0);
        chk("abort.done",   32'(done),   0);
        chk("abort.steps",  32'(steps),  0);
        chk("abort.found",  32'(found),  0);
        chk("abort.err",    32'(err),    0);
        chk("abort.result", 32'(result), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort.no_done", 32'(done), 0);
            chk("abort.idle",    32'(busy), 0);
        end

        // start held through the done pulse starts the next search immediately
        run_search(0, 5, 0, 1'b0, 1'b1, "hold1");
        @(negedge clk);
        start = 1'b0;
        chk("hold2.busy",   32'(busy),   1);
        chk("hold2.probe",  32'(probe),  7);
        chk("hold2.steps",  32'(steps),  0);
        chk("hold2.found",  32'(found),  0);
        chk("hold2.result", 32'(result), 0);
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("hold2.done_seen", 32'(seen),   1);
        chk("hold2.found_end", 32'(found),  1);
        chk("hold2.result_end", 32'(result), 5);
        chk("hold2.steps_end", 32'(steps),  3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
